// File: rtl/budget_arbiter_if.sv
// budget_arbiter_if
//   Grant bus between a budget-limited round-robin arbiter and its consumer.
//   master : arbiter side  (drives valid/selection/best_effort/exhausted/period_start)
//   slave  : consumer side (drives budgets/period/empty/ready)
//   budgets      : per-queue transactions allowed per period
//   period       : replenishment period in cycles
//   empty        : bit i high = queue i has nothing pending
//   ready        : consumer accepts the current grant
//   valid        : grant present on selection
//   selection    : granted queue index
//   best_effort  : current grant is over budget
//   exhausted    : bit i high when queue i has used its budget
//   period_start : one-cycle pulse after counts were replenished
interface budget_arbiter_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 8
);
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] budgets;
  logic [REGISTER_SIZE-1:0]                       period;
  logic [NUMBER_OF_QUEUES-1:0]                    empty;
  logic                                           ready;
  logic                                           valid;
  logic [SEL_W-1:0]                               selection;
  logic                                           best_effort;
  logic [NUMBER_OF_QUEUES-1:0]                    exhausted;
  logic                                           period_start;

  modport master (
    input  budgets, period, empty, ready,
    output valid, selection, best_effort, exhausted, period_start
  );

  modport slave (
    output budgets, period, empty, ready,
    input  valid, selection, best_effort, exhausted, period_start
  );
endinterface

// File: rtl/budget_arbiter.sv
// budget_arbiter
//   Round-robin arbiter over NUMBER_OF_QUEUES request queues where each queue
//   may be granted at most budgets[i] times per replenishment period. With
//   WORK_CONSERVING set, non-empty queues still get best-effort grants once
//   every non-empty queue is out of budget.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low
//     bus   : budget_arbiter_if.master (budgets/period/empty/ready in,
//             valid/selection/best_effort/exhausted/period_start out)

// Per-queue usage counter. count_next is exposed through eligible_next so the
// arbiter can decide on post-handshake, post-replenishment counts.
module budget_arbiter_lane #(
  parameter int REGISTER_SIZE = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REGISTER_SIZE-1:0] budget,
  input  logic                     empty,
  input  logic                     charge,
  input  logic                     replenish,
  output logic                     eligible_next,
  output logic                     exhausted
);
  localparam int W = REGISTER_SIZE;

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (charge && !(&count)) count_next = count + 1'b1;
    // Replenish wins; a grant taken on the same edge is billed to the new period.
    if (replenish) count_next = W'(charge);
  end

  always_ff @(posedge clock) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end

  assign eligible_next = !empty && (count_next < budget);
  assign exhausted     = (count >= budget);
endmodule

module budget_arbiter #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 8,
  parameter int WORK_CONSERVING  = 0
) (
  input logic              clock,
  input logic              reset,
  budget_arbiter_if.master bus
);
  localparam int N     = NUMBER_OF_QUEUES;
  localparam int W     = REGISTER_SIZE;
  localparam int SEL_W = $clog2(N);

  logic [W-1:0]     pc;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic             valid_q;
  logic [SEL_W-1:0] sel_q;
  logic             be_q;
  logic             ps_q;

  logic             handshake;
  logic             replenish;
  logic [N-1:0]     charge;
  logic [N-1:0]     eligible_next;
  logic [N-1:0]     exhausted;

  logic             found_budget;
  logic             found_any;
  logic [SEL_W-1:0] pick_budget;
  logic [SEL_W-1:0] pick_any;
  logic [SEL_W:0]   idx_w;
  logic [SEL_W-1:0] idx;

  assign handshake = valid_q & bus.ready;

  // Period 0/1 replenishes every edge; pc >= period-1 also catches a period
  // that was lowered below the running count.
  assign replenish = (bus.period < W'(2)) || (pc >= bus.period - W'(1));

  always_comb begin
    charge = '0;
    for (int i = 0; i < N; i++) charge[i] = handshake && (sel_q == SEL_W'(i));
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      budget_arbiter_lane #(.REGISTER_SIZE(W)) u_lane (
        .clock         (clock),
        .reset         (reset),
        .budget        (bus.budgets[g]),
        .empty         (bus.empty[g]),
        .charge        (charge[g]),
        .replenish     (replenish),
        .eligible_next (eligible_next[g]),
        .exhausted     (exhausted[g])
      );
    end
  endgenerate

  // Pointer moves past the queue just served; wraps at N-1 for any N.
  always_comb begin
    ptr_next = ptr;
    if (handshake) ptr_next = (sel_q == SEL_W'(N-1)) ? '0 : sel_q + 1'b1;
  end

  // Two rotating priority searches from ptr_next: within budget, and any
  // non-empty queue for the best-effort fallback.
  always_comb begin
    found_budget = 1'b0;
    found_any    = 1'b0;
    pick_budget  = ptr_next;
    pick_any     = ptr_next;
    idx_w        = '0;
    idx          = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, ptr_next} + (SEL_W+1)'(k);
      if (idx_w >= (SEL_W+1)'(N)) idx_w = idx_w - (SEL_W+1)'(N);
      idx = idx_w[SEL_W-1:0];
      if (!found_budget && eligible_next[idx]) begin
        found_budget = 1'b1;
        pick_budget  = idx;
      end
      if (!found_any && !bus.empty[idx]) begin
        found_any = 1'b1;
        pick_any  = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc      <= '0;
      ptr     <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      be_q    <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      pc   <= replenish ? '0 : pc + 1'b1;
      ptr  <= ptr_next;
      ps_q <= replenish;
      // A stalled grant holds; a new decision loads when idle or on handshake.
      if (!valid_q || handshake) begin
        if (found_budget) begin
          valid_q <= 1'b1;
          sel_q   <= pick_budget;
          be_q    <= 1'b0;
        end else if ((WORK_CONSERVING != 0) && found_any) begin
          valid_q <= 1'b1;
          sel_q   <= pick_any;
          be_q    <= 1'b1;
        end else begin
          valid_q <= 1'b0;
          be_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.valid        = valid_q;
  assign bus.selection    = sel_q;
  assign bus.best_effort  = be_q;
  assign bus.exhausted    = exhausted;
  assign bus.period_start = ps_q;
endmodule

// File: tb/tb_budget_arbiter.sv
// tb_budget_arbiter
//   Three arbiters side by side: u0 (N=4), u1 (N=4, work-conserving),
//   u2 (N=3). Directed scenarios check fixed expected sequences; the random
//   phase compares every output against a cycle-level reference model.
module tb_budget_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [3:0][7:0] b0, b1;
  logic [2:0][7:0] b2;
  logic [7:0]      p0, p1, p2;
  logic [3:0]      e0, e1;
  logic [2:0]      e2;
  logic            r0, r1, r2;

  budget_arbiter_if #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(8)) bus0 ();
  budget_arbiter_if #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(8)) bus1 ();
  budget_arbiter_if #(.NUMBER_OF_QUEUES(3), .REGISTER_SIZE(8)) bus2 ();

  assign bus0.budgets = b0; assign bus0.period = p0; assign bus0.empty = e0; assign bus0.ready = r0;
  assign bus1.budgets = b1; assign bus1.period = p1; assign bus1.empty = e1; assign bus1.ready = r1;
  assign bus2.budgets = b2; assign bus2.period = p2; assign bus2.empty = e2; assign bus2.ready = r2;

  budget_arbiter #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(8), .WORK_CONSERVING(0))
    u0 (.clock(clock), .reset(reset), .bus(bus0));
  budget_arbiter #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(8), .WORK_CONSERVING(1))
    u1 (.clock(clock), .reset(reset), .bus(bus1));
  budget_arbiter #(.NUMBER_OF_QUEUES(3), .REGISTER_SIZE(8), .WORK_CONSERVING(0))
    u2 (.clock(clock), .reset(reset), .bus(bus2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  int nq [3] = '{4, 4, 3};
  bit wc [3] = '{1'b0, 1'b1, 1'b0};
  int mc [3][16];
  int mptr [3];
  int mpc [3];
  int ms [3];
  bit mv [3];
  bit mbe [3];
  bit mps [3];

  function automatic int bud(int d, int i);
    case (d)
      0:       return int'(b0[i]);
      1:       return int'(b1[i]);
      default: return int'(b2[i]);
    endcase
  endfunction

  function automatic bit emp(int d, int i);
    case (d)
      0:       return e0[i];
      1:       return e1[i];
      default: return e2[i];
    endcase
  endfunction

  function automatic int per(int d);
    case (d)
      0:       return int'(p0);
      1:       return int'(p1);
      default: return int'(p2);
    endcase
  endfunction

  function automatic bit rdy(int d);
    case (d)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic [6:0] got_out(int d);
    case (d)
      0:       return {bus0.valid, 4'(bus0.selection), bus0.best_effort, bus0.period_start};
      1:       return {bus1.valid, 4'(bus1.selection), bus1.best_effort, bus1.period_start};
      default: return {bus2.valid, 4'(bus2.selection), bus2.best_effort, bus2.period_start};
    endcase
  endfunction

  function automatic logic [15:0] got_exh(int d);
    case (d)
      0:       return 16'(bus0.exhausted);
      1:       return 16'(bus1.exhausted);
      default: return 16'(bus2.exhausted);
    endcase
  endfunction

  // Next state of arbiter d given the inputs present before the coming edge.
  function automatic void model_step(int d);
    int  n = nq[d];
    int  c [16];
    int  ptr;
    int  pick;
    bit  be;
    bit  hs;
    bit  repl;
    if (!reset) begin
      for (int i = 0; i < 16; i++) mc[d][i] = 0;
      mptr[d] = 0; mpc[d] = 0; ms[d] = 0; mv[d] = 0; mbe[d] = 0; mps[d] = 0;
      return;
    end
    hs   = mv[d] && rdy(d);
    repl = (per(d) <= 1) || (mpc[d] >= per(d) - 1);
    for (int i = 0; i < n; i++) begin
      c[i] = mc[d][i];
      if (hs && i == ms[d]) c[i] = (c[i] == 255) ? 255 : c[i] + 1;
      if (repl) c[i] = (hs && i == ms[d]) ? 1 : 0;
    end
    ptr     = hs ? (ms[d] + 1) % n : mptr[d];
    mpc[d]  = repl ? 0 : mpc[d] + 1;
    mps[d]  = repl;
    if (!mv[d] || hs) begin
      pick = -1;
      be   = 1'b0;
      for (int k = 0; k < n; k++) begin
        int i = (ptr + k) % n;
        if (!emp(d, i) && c[i] < bud(d, i)) begin pick = i; break; end
      end
      if (pick < 0 && wc[d]) begin
        for (int k = 0; k < n; k++) begin
          int i = (ptr + k) % n;
          if (!emp(d, i)) begin pick = i; be = 1'b1; break; end
        end
      end
      if (pick >= 0) begin mv[d] = 1'b1; ms[d] = pick; mbe[d] = be; end
      else           begin mv[d] = 1'b0; mbe[d] = 1'b0; end
    end
    for (int i = 0; i < n; i++) mc[d][i] = c[i];
    mptr[d] = ptr;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    b0 = '0; b1 = {4{8'd1}}; b2 = {3{8'd3}};
    p0 = 8'd10; p1 = 8'd10; p2 = 8'd10;
    e0 = '0; e1 = '0; e2 = '0; r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    tick(); tick();
    checks++;
    if ({bus0.valid, bus0.selection, bus0.best_effort, bus0.period_start} !== 5'd0) begin
      failures++; $display("FAIL reset_out0 got=%h exp=0", {bus0.valid, bus0.selection, bus0.best_effort, bus0.period_start});
    end
    checks++;
    if (bus0.exhausted !== 4'hF) begin
      failures++; $display("FAIL reset_exh0 got=%h exp=f", bus0.exhausted);
    end
    checks++;
    if (bus1.exhausted !== 4'h0) begin
      failures++; $display("FAIL reset_exh1 got=%h exp=0", bus1.exhausted);
    end
    checks++;
    if ({bus2.valid, bus2.selection, bus2.best_effort, bus2.period_start} !== 5'd0) begin
      failures++; $display("FAIL reset_out2 got=%h exp=0", {bus2.valid, bus2.selection, bus2.best_effort, bus2.period_start});
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b0;
    b0 = {4{8'd2}}; p0 = 8'd20; e0 = '0; r0 = 1'b1;
    tick();
    reset = 1'b1;
    for (int g = 0; g < 8; g++) begin
      tick();
      checks++;
      if ({bus0.valid, bus0.selection, bus0.best_effort} !== {1'b1, 2'(g % 4), 1'b0}) begin
        failures++; $display("FAIL b2b_grant[%0d] got=%h exp=%h", g,
                             {bus0.valid, bus0.selection, bus0.best_effort}, {1'b1, 2'(g % 4), 1'b0});
      end
    end
    tick();
    checks++;
    if (bus0.valid !== 1'b0 || bus0.exhausted !== 4'hF) begin
      failures++; $display("FAIL b2b_exhausted got v=%b exh=%h exp v=0 exh=f", bus0.valid, bus0.exhausted);
    end
    for (int k = 10; k < 20; k++) begin
      tick();
      checks++;
      if (bus0.valid !== 1'b0 || bus0.period_start !== 1'b0) begin
        failures++; $display("FAIL b2b_idle[%0d] got v=%b ps=%b exp 0 0", k, bus0.valid, bus0.period_start);
      end
    end
    tick();
    checks++;
    if ({bus0.valid, bus0.selection, bus0.period_start, bus0.exhausted} !== {1'b1, 2'd0, 1'b1, 4'h0}) begin
      failures++; $display("FAIL b2b_replenish got=%h exp=%h",
                           {bus0.valid, bus0.selection, bus0.period_start, bus0.exhausted}, {1'b1, 2'd0, 1'b1, 4'h0});
    end
  endtask

  task automatic test_stall();
    reset = 1'b0;
    b0 = {8'd4, 8'd1, 8'd4, 8'd4}; p0 = 8'd200; e0 = 4'b0011; r0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus0.valid, bus0.selection} !== 3'b110) begin
      failures++; $display("FAIL stall_first got=%b exp=110", {bus0.valid, bus0.selection});
    end
    for (int s = 0; s < 5; s++) begin
      if (s == 1) e0[2] = 1'b1;
      if (s == 2) b0[0] = 8'd7;
      if (s == 3) b0[2] = 8'd0;
      if (s == 4) b0[2] = 8'd1;
      tick();
      checks++;
      if ({bus0.valid, bus0.selection, bus0.best_effort} !== 4'b1100) begin
        failures++; $display("FAIL stall_hold[%0d] got=%b exp=1100", s, {bus0.valid, bus0.selection, bus0.best_effort});
      end
    end
    r0 = 1'b1;
    tick();
    checks++;
    if ({bus0.valid, bus0.selection, bus0.exhausted} !== {1'b1, 2'd3, 4'b0100}) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", {bus0.valid, bus0.selection, bus0.exhausted}, {1'b1, 2'd3, 4'b0100});
    end
    r0 = 1'b0;
  endtask

  task automatic test_work_conserving();
    logic [2:0] exp;
    reset = 1'b0;
    b1 = {8'd0, 8'd1, 8'd0, 8'd0}; p1 = 8'd255; e1 = 4'b1010; r1 = 1'b1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0)          exp = {1'b1, 2'd2} ;
      else if (k % 2 == 1) exp = {1'b1, 2'd0};
      else                 exp = {1'b1, 2'd2};
      checks++;
      if ({bus1.valid, bus1.selection} !== exp || bus1.best_effort !== (k != 0)) begin
        failures++; $display("FAIL wc_grant[%0d] got v/sel=%b be=%b exp v/sel=%b be=%b",
                             k, {bus1.valid, bus1.selection}, bus1.best_effort, exp, (k != 0));
      end
    end
    checks++;
    if (bus1.exhausted !== 4'hF) begin
      failures++; $display("FAIL wc_exh got=%h exp=f", bus1.exhausted);
    end
  endtask

  task automatic test_replenish_collision();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    reset = 1'b0;
    b0 = {4{8'd3}}; p0 = 8'd5; e0 = 4'b1100; r0 = 1'b1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus0.valid, bus0.selection, bus0.period_start} !== {1'b1, seq[k], (k == 4)}) begin
        failures++; $display("FAIL coll_edge[%0d] got=%b exp=%b", k,
                             {bus0.valid, bus0.selection, bus0.period_start}, {1'b1, seq[k], (k == 4)});
      end
    end
    b0 = {4{8'd1}};
    #1;
    checks++;
    if (bus0.exhausted !== 4'b0010) begin
      failures++; $display("FAIL coll_counts got=%b exp=0010", bus0.exhausted);
    end
    tick();
    checks++;
    if (bus0.period_start !== 1'b0) begin
      failures++; $display("FAIL coll_pulse got=%b exp=0", bus0.period_start);
    end
  endtask

  task automatic test_n3_wrap_reset();
    reset = 1'b0;
    b2 = {3{8'd2}}; p2 = 8'd100; e2 = '0; r2 = 1'b1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus2.valid, bus2.selection} !== {1'b1, 2'(k % 3)}) begin
        failures++; $display("FAIL n3_wrap[%0d] got=%b exp=%b", k, {bus2.valid, bus2.selection}, {1'b1, 2'(k % 3)});
      end
    end
    b2 = {3{8'd1}};
    #1;
    checks++;
    if (bus2.exhausted !== 3'b111) begin
      failures++; $display("FAIL n3_pre_reset_exh got=%b exp=111", bus2.exhausted);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus2.valid !== 1'b0 || bus2.exhausted !== 3'b000) begin
      failures++; $display("FAIL n3_reset got v=%b exh=%b exp v=0 exh=000", bus2.valid, bus2.exhausted);
    end
    reset = 1'b1;
    b2 = {3{8'd2}};
    tick();
    checks++;
    if ({bus2.valid, bus2.selection} !== 3'b100) begin
      failures++; $display("FAIL n3_first got=%b exp=100", {bus2.valid, bus2.selection});
    end
  endtask

  task automatic test_period_zero();
    reset = 1'b0;
    b0 = {4{8'd1}}; p0 = 8'd0; e0 = '0; r0 = 1'b1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({bus0.valid, bus0.selection, bus0.period_start} !== {1'b1, 2'(k % 4), 1'b1}) begin
        failures++; $display("FAIL p0_rotate[%0d] got=%b exp=%b", k,
                             {bus0.valid, bus0.selection, bus0.period_start}, {1'b1, 2'(k % 4), 1'b1});
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  exp_o;
    logic [15:0] exp_e;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = (cyc == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) b0[i] = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) b1[i] = 8'($urandom_range(0, 3));
      end
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 7) == 0) b2[i] = 8'($urandom_range(0, 3));
      if (cyc % 40 == 0) begin
        p0 = 8'($urandom_range(0, 12));
        p1 = 8'($urandom_range(0, 12));
        p2 = 8'($urandom_range(0, 12));
      end
      e0 = 4'($urandom); e1 = 4'($urandom); e2 = 3'($urandom);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 3; d++) model_step(d);
      tick();
      for (int d = 0; d < 3; d++) begin
        exp_o = {mv[d], 4'(ms[d]), mbe[d], mps[d]};
        exp_e = '0;
        for (int i = 0; i < nq[d]; i++) exp_e[i] = (mc[d][i] >= bud(d, i));
        checks++;
        if (got_out(d) !== exp_o) begin
          failures++; $display("FAIL rand_out u%0d cyc=%0d got v/sel/be/ps=%h exp=%h", d, cyc, got_out(d), exp_o);
        end
        checks++;
        if (got_exh(d) !== exp_e) begin
          failures++; $display("FAIL rand_exh u%0d cyc=%0d got=%h exp=%h", d, cyc, got_exh(d), exp_e);
        end
      end
    end
  endtask

  initial begin
    b0 = '0; b1 = '0; b2 = '0;
    p0 = '0; p1 = '0; p2 = '0;
    e0 = '1; e1 = '1; e2 = '1;
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_work_conserving();
    test_replenish_collision();
    test_n3_wrap_reset();
    test_period_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/budget_arbiter.md
BUDGET_ARBITER -- requirements
Module: budget_arbiter

Interface
REQ-001 Parameter NUMBER_OF_QUEUES, default 4: number of request queues, legal range 2..16, need not be a power of two.
REQ-002 Parameter REGISTER_SIZE, default 8: width of budgets, counters and period.
REQ-003 Parameter WORK_CONSERVING, default 0: 1 enables best-effort grants once all non-empty queues are exhausted.
REQ-004 clock  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-006 budgets  input  NUMBER_OF_QUEUES x REGISTER_SIZE: per-queue transactions allowed per period, sampled live every cycle.
REQ-007 period  input  REGISTER_SIZE: replenishment period in cycles, sampled live.
REQ-008 empty  input  NUMBER_OF_QUEUES: bit i high = queue i has no pending transaction.
REQ-009 ready  input  1: downstream accepts the current grant.
REQ-010 valid  output  1: grant present on selection.
REQ-011 selection  output  $clog2(NUMBER_OF_QUEUES): granted queue index.
REQ-012 best_effort  output  1: current grant is a best-effort (over-budget) grant.
REQ-013 exhausted  output  NUMBER_OF_QUEUES: bit i high when count[i] >= budgets[i].
REQ-014 period_start  output  1: one-cycle pulse in the cycle the counts read zero after replenishment.

Function
REQ-015 Per-queue counter count[i], REGISTER_SIZE bits, saturating at all-ones; never wraps.
REQ-016 Queue i eligible when !empty[i] and count[i] < budgets[i]; a budget of 0 makes it never eligible.
REQ-017 Round-robin pointer ptr; search order is ptr, ptr+1, ... modulo NUMBER_OF_QUEUES, wrapping at N-1 to 0 for non-power-of-two N.
REQ-018 valid, selection and best_effort are registered: a new decision is loaded whenever valid is 0 or (valid and ready); otherwise all three hold unchanged.
REQ-019 Decision: first eligible queue in search order gives valid=1, best_effort=0.
REQ-020 With no eligible queue, WORK_CONSERVING=1 and some queue non-empty, the first non-empty queue in search order gives valid=1, best_effort=1.
REQ-021 Otherwise the decision is valid=0, and selection holds its previous value.
REQ-022 Latency is one cycle, from a queue becoming empty=0 with budget available while idle, to valid=1.
REQ-023 A held grant does not change if empty or budgets change while stalled (valid=1, ready=0).
REQ-024 A handshake is valid and ready at a clock edge.
REQ-025 On a handshake, count[selection] increments with saturation (best-effort grants also increment) and ptr becomes selection+1 modulo N.
REQ-026 A decision loaded in the same edge as a handshake uses the post-handshake ptr and counts, giving back-to-back grants with no bubble.
REQ-027 Period counter pc runs 0..period-1; when pc == period-1, the next edge sets pc=0 and clears all counts, and period_start=1 in the following cycle.
REQ-028 period of 0 or 1 replenishes every cycle.
REQ-029 On a period reduction, pc >= period replenishes at the next edge.
REQ-030 When replenishment and a handshake coincide, replenishment wins, and the handshaked queue's count becomes 1 (charged to the new period) while all others become 0.
REQ-031 exhausted is combinational from count and budgets.

Reset
REQ-032 reset=0 at a rising edge sets valid=0, selection=0, best_effort=0, period_start=0, ptr=0, all counts=0 and pc=0.
REQ-033 reset has priority over handshake and replenishment, including mid-grant: an outstanding grant is dropped without charge.
REQ-034 The first decision is loaded on the first edge with reset=1.

Verification
REQ-035 N=4, budgets all 2, period=20, empty=0000, ready=1 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, then valid=0 until replenishment; exhausted=1111 after the 8th grant.
REQ-036 Stall: valid=1, selection=2, ready=0 for 5 cycles while empty[2] rises -> selection stays 2; on ready=1, count[2] increments and the next grant is 3.
REQ-037 WORK_CONSERVING=1, budgets {0,0,1,0}, empty=1010 -> grant 2 with best_effort=0, then alternating 0 and 2 with best_effort=1; counts saturate at 255 without wrap.
REQ-038 period=5, handshake on queue 1 at the edge where pc=4 -> count[1]=1, others 0, period_start=1 next cycle.
REQ-039 N=3: ptr wraps 2->0; reset=0 asserted with valid=1 -> valid=0 next cycle, counts 0, first post-reset grant is queue 0.
REQ-040 period=0 with budgets all 1 and ready=1 -> counts re-zeroed every cycle and grants rotate 0,1,2,... without stall.
